// File: rtl/st_sequence_source.sv
// st_sequence_source: Avalon-ST source that emits a bounded burst of
// incrementing words on a start command. An optional LFSR throttle inserts
// pseudo-random valid gaps. Progress (sent_count) and completion (done)
// are reported to the controlling sequencer.
module st_sequence_source #(
   parameter int          DATA_WIDTH   = 36,
   parameter int          COUNT_WIDTH  = 16,
   parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] word_count,
   input  logic [DATA_WIDTH-1:0]  start_value,
   input  logic                   throttle_en,
   input  logic [15:0]            seed,
   output logic                   out_valid,
   output logic [DATA_WIDTH-1:0]  out_data,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] sent_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state_q, state_d;
   logic                   thr_q, thr_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [15:0]            lfsr_q, lfsr_d;
   logic                   valid_d;
   logic [DATA_WIDTH-1:0]  data_d;
   logic [COUNT_WIDTH-1:0] sent_d;
   logic                   done_d;

   logic        accept;
   logic        gate;
   logic [15:0] lfsr_load;
   logic        lfsr_fb;

   assign accept    = out_valid && out_ready;
   assign gate      = !thr_q || lfsr_q[0];
   assign lfsr_load = (seed == 16'd0) ? LFSR_DEFAULT : seed;
   // Fibonacci taps 16,14,13,11 expressed on a left-shifting register.
   assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign busy      = (state_q == RUN);

   // Next-state and next-value logic for the FSM and its datapath.
   always_comb begin
      // NOTE: every target gets a hold/default value first so no path can
      // leave it unassigned and infer a latch.
      state_d     = state_q;
      thr_d       = thr_q;
      remaining_d = remaining_q;
      lfsr_d      = lfsr_q;
      valid_d     = out_valid;
      data_d      = out_data;
      sent_d      = sent_count;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               thr_d       = throttle_en;
               lfsr_d      = lfsr_load;
               sent_d      = '0;
               remaining_d = word_count;
               if (word_count == '0) begin
                  // Empty burst: report completion without ever going busy.
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
                  data_d  = start_value;
                  valid_d = !throttle_en || lfsr_load[0];
               end
            end
         end

         RUN: begin
            if (thr_q) lfsr_d = {lfsr_q[14:0], lfsr_fb};
            if (accept) begin
               sent_d      = sent_count + COUNT_WIDTH'(1);
               remaining_d = remaining_q - COUNT_WIDTH'(1);
               data_d      = out_data + DATA_WIDTH'(1);
               if (remaining_q == COUNT_WIDTH'(1)) begin
                  valid_d = 1'b0;
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  valid_d = gate;
               end
            end else if (!out_valid) begin
               // A presented word is never withdrawn; only an idle slot
               // may be (re)gated.
               valid_d = gate;
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; async reset to the idle values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         thr_q       <= 1'b0;
         remaining_q <= '0;
         lfsr_q      <= LFSR_DEFAULT;
         out_valid   <= 1'b0;
         out_data    <= '0;
         sent_count  <= '0;
         done        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         state_q     <= state_d;
         thr_q       <= thr_d;
         remaining_q <= remaining_d;
         lfsr_q      <= lfsr_d;
         out_valid   <= valid_d;
         out_data    <= data_d;
         sent_count  <= sent_d;
         done        <= done_d;
      end
   end

endmodule

// File: doc/st_sequence_source.md
Name: st_sequence_source

Overview:
- Avalon-ST source that generates a bounded burst of incrementing 36-bit words on command.
- Feeds the data_in sink of the 8-deep timing adapter FIFO, the transmit end of that valid/ready interface (ready latency 0).
- Optional LFSR throttle inserts pseudo-random valid gaps to exercise FIFO fill/empty corners.
- Reports progress and completion to a controlling sequencer or bench.

Parameters:
- DATA_WIDTH, 36, width of out_data and start_value.
- COUNT_WIDTH, 16, width of word_count and sent_count.
- LFSR_DEFAULT, 16'hACE1, LFSR load value used when seed is 0.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command pulse; ignored while busy=1.
- word_count  input  COUNT_WIDTH  number of words to send; sampled with start.
- start_value  input  DATA_WIDTH  first data word; sampled with start.
- throttle_en  input  1  1 = LFSR-gated valid; 0 = valid whenever a word is pending. Sampled with start.
- seed  input  16  LFSR seed; sampled with start.
- out_valid  output  1  Avalon-ST valid.
- out_data  output  DATA_WIDTH  Avalon-ST data.
- out_ready  input  1  Avalon-ST ready from the sink (the FIFO's in_ready).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the burst completes.
- sent_count  output  COUNT_WIDTH  words accepted since the last accepted start.

Behaviour:
- Reset (async assert, sync release), all outputs and state cleared:
  - out_valid=0, out_data=0, busy=0, done=0, sent_count=0.
  - state=IDLE, remaining=0, lfsr=LFSR_DEFAULT.
- States: IDLE, RUN, DONE. All registers update on the rising edge of clk.
- Accept: a transfer occurs on any edge where out_valid && out_ready.
- Gate: gate = !thr || lfsr[0], where thr is the throttle_en value latched at start.
- IDLE with start=1:
  - Latch thr, start_value, word_count.
  - lfsr <= (seed==0) ? LFSR_DEFAULT : seed.
  - sent_count <= 0.
- IDLE, start with word_count==0:
  - Stay in IDLE, pulse done next cycle. busy and out_valid stay 0.
- IDLE, start with word_count!=0:
  - Enter RUN (busy=1 from the next cycle).
  - out_data <= start_value.
  - remaining <= word_count.
  - out_valid <= gate evaluated on the loaded seed.
  - Minimum latency start→first valid is 1 cycle.
- RUN, LFSR:
  - Advances every cycle when thr=1: 16-bit Fibonacci, taps 16,14,13,11.
  - Shift left, new bit0 = b15^b13^b12^b10.
  - Frozen when thr=0.
- RUN, out_valid=0: out_valid <= gate (current lfsr).
- RUN, out_valid=1 and no accept:
  - out_valid and out_data hold; valid is never withdrawn before acceptance.
- RUN, accept:
  - sent_count+1, remaining-1, out_data+1 (wraps modulo 2^DATA_WIDTH, no saturation).
  - If remaining==1: out_valid <= 0, go to DONE.
  - Otherwise: out_valid <= gate, so back-to-back transfers occur every cycle when thr=0 and out_ready=1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start during DONE is ignored.
- start during RUN is ignored. Latched parameters and in-flight data are unaffected.
- sent_count holds its final value in IDLE until the next accepted start.
- Reset mid-burst: immediate abandon, all outputs return to reset values. No done pulse follows.
- Output stability: out_data changes only on accept or start, never while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then start with word_count=5, start_value=0, throttle_en=0, out_ready=1 → out_valid high 5 consecutive cycles from 1 cycle after start; data 0,1,2,3,4; done pulses once; sent_count=5.
- Drive into the 8-deep FIFO, word_count=12, FIFO out_ready=0 → 8 words accepted, out_valid held high with out_data=8 stable while in_ready=0. Then drain at 1/cycle → all 12 words arrive in order; done pulses after word 11 is accepted.
- start_value=36'hFFFFFFFFE, word_count=4, throttle_en=0 → data FFFFFFFFE, FFFFFFFFF, 000000000, 000000001.
- throttle_en=1, seed=0, word_count=100, out_ready random 50% → LFSR starts at ACE1; exactly 100 accepts, sequential data, no valid deassertion before accept, no data change while stalled.
- start with word_count=0 → no out_valid; done high exactly 1 cycle after start; busy stays 0. start pulsed during RUN → no restart, sequence continues.
- Assert reset_n=0 mid-burst (after 3 of 10 accepts) → out_valid, busy and sent_count drop to 0 asynchronously; no done pulse. A new start after release runs a clean burst.
